// File: rtl/posit_decode_arb_if.sv
// Handshake bundle between two posit requesters, the shared decoder front end
// and its consumer.
interface posit_decode_arb_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned ES = 1,
  parameter int unsigned S  = $clog2(N)
);
  logic          req0_valid;
  logic [N-1:0]  req0_bits;
  logic          req0_ready;
  logic          req1_valid;
  logic [N-1:0]  req1_bits;
  logic          req1_ready;
  logic          out_valid;
  logic          out_ready;
  logic          out_id;
  logic          out_is_zero;
  logic          out_is_inf;
  logic          out_sign;
  logic          out_reg_s;
  logic [S:0]    out_reg_len;
  logic [S:0]    out_k;
  logic [ES-1:0] out_exp;
  logic [N-1:0]  out_mant;

  // Requesters and consumer side
  modport master (
    output req0_valid, req0_bits, req1_valid, req1_bits, out_ready,
    input  req0_ready, req1_ready, out_valid, out_id, out_is_zero, out_is_inf,
           out_sign, out_reg_s, out_reg_len, out_k, out_exp, out_mant
  );

  // Arbiter/decoder side
  modport slave (
    input  req0_valid, req0_bits, req1_valid, req1_bits, out_ready,
    output req0_ready, req1_ready, out_valid, out_id, out_is_zero, out_is_inf,
           out_sign, out_reg_s, out_reg_len, out_k, out_exp, out_mant
  );
endinterface

// File: rtl/posit_decode_arb.sv
// Round-robin arbiter sharing one combinational posit decoder between two
// requesters, with a one-entry registered output stage.

module posit_decode #(
  parameter int unsigned N  = 16,
  parameter int unsigned ES = 1,
  parameter int unsigned S  = $clog2(N)
) (
  input  logic [N-1:0]  bits,
  output logic          is_zero,
  output logic          is_inf,
  output logic          sign,
  output logic          reg_s,
  output logic [S:0]    reg_len,
  output logic [S:0]    k,
  output logic [ES-1:0] exp,
  output logic [N-1:0]  mant
);
  localparam int unsigned W = N - 1;

  logic [W-1:0] rest;
  logic [W-1:0] shifted;
  logic         stop;
  int           run;
  int           len;
  int           mbits;

  always_comb begin
    sign    = bits[N-1];
    is_zero = (bits == '0);
    is_inf  = sign && (bits[N-2:0] == '0);
    rest    = sign ? W'(-bits) : bits[N-2:0];
    reg_s   = rest[W-1];
    run     = 0;
    stop    = 1'b0;
    // Regime is the run of bits equal to the first one after the sign
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (!stop && (rest[i] == reg_s)) run = run + 1;
      else stop = 1'b1;
    end
    len     = run + 1;
    shifted = rest << len;
    exp     = shifted[W-1 -: ES];
    mbits   = int'(W) - len - int'(ES);
    mant    = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (i < mbits) mant[i] = rest[i];
    end
    reg_len = (S+1)'(len);
    k       = reg_s ? (S+1)'(run - 1) : (S+1)'(-run);
    // Zero and NaR carry no regime/exponent/fraction
    if (is_zero || is_inf) begin
      reg_s   = 1'b0;
      reg_len = '0;
      k       = '0;
      exp     = '0;
      mant    = '0;
    end
  end
endmodule

module posit_decode_arb #(
  parameter int unsigned N  = 16,
  parameter int unsigned ES = 1,
  parameter int unsigned S  = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  posit_decode_arb_if.slave   bus
);
  logic          rr;
  logic          gnt0, gnt1, free, accept;
  logic [N-1:0]  dec_bits;
  logic          d_is_zero, d_is_inf, d_sign, d_reg_s;
  logic [S:0]    d_reg_len, d_k;
  logic [ES-1:0] d_exp;
  logic [N-1:0]  d_mant;

  logic          out_valid, out_id, out_is_zero, out_is_inf, out_sign, out_reg_s;
  logic [S:0]    out_reg_len, out_k;
  logic [ES-1:0] out_exp;
  logic [N-1:0]  out_mant;

  // Grant depends only on valids and the priority pointer
  always_comb begin
    gnt0     = bus.req0_valid && (!bus.req1_valid || !rr);
    gnt1     = bus.req1_valid && (!bus.req0_valid || rr);
    free     = !out_valid || bus.out_ready;
    accept   = free && (gnt0 || gnt1);
    dec_bits = gnt1 ? bus.req1_bits : bus.req0_bits;
  end

  assign bus.req0_ready = free && gnt0;
  assign bus.req1_ready = free && gnt1;

  posit_decode #(.N(N), .ES(ES), .S(S)) u_dec (
    .bits    (dec_bits),
    .is_zero (d_is_zero),
    .is_inf  (d_is_inf),
    .sign    (d_sign),
    .reg_s   (d_reg_s),
    .reg_len (d_reg_len),
    .k       (d_k),
    .exp     (d_exp),
    .mant    (d_mant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr          <= 1'b0;
      out_valid   <= 1'b0;
      out_id      <= 1'b0;
      out_is_zero <= 1'b0;
      out_is_inf  <= 1'b0;
      out_sign    <= 1'b0;
      out_reg_s   <= 1'b0;
      out_reg_len <= '0;
      out_k       <= '0;
      out_exp     <= '0;
      out_mant    <= '0;
    end else if (accept) begin
      rr          <= !gnt1;
      out_valid   <= 1'b1;
      out_id      <= gnt1;
      out_is_zero <= d_is_zero;
      out_is_inf  <= d_is_inf;
      out_sign    <= d_sign;
      out_reg_s   <= d_reg_s;
      out_reg_len <= d_reg_len;
      out_k       <= d_k;
      out_exp     <= d_exp;
      out_mant    <= d_mant;
    end else if (bus.out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  assign bus.out_valid   = out_valid;
  assign bus.out_id      = out_id;
  assign bus.out_is_zero = out_is_zero;
  assign bus.out_is_inf  = out_is_inf;
  assign bus.out_sign    = out_sign;
  assign bus.out_reg_s   = out_reg_s;
  assign bus.out_reg_len = out_reg_len;
  assign bus.out_k       = out_k;
  assign bus.out_exp     = out_exp;
  assign bus.out_mant    = out_mant;
endmodule

// File: tb/tb_posit_decode_arb.sv
// Directed bench for posit_decode_arb (N=16, ES=1): reset, decode vectors,
// fairness, backpressure and asynchronous mid-stream reset.
module tb_posit_decode_arb;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  posit_decode_arb_if #(.N(16), .ES(1)) bus ();

  posit_decode_arb #(.N(16), .ES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle transfer from a single requester, output drained immediately
  task automatic send(input logic sel, input logic [15:0] w);
    bus.req0_valid = !sel;
    bus.req1_valid = sel;
    bus.req0_bits  = w;
    bus.req1_bits  = w;
    bus.out_ready  = 1'b1;
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic dec(input string tag, input logic sel, input logic [15:0] w,
                     input logic zero, input logic inf, input logic sgn,
                     input logic [4:0] len, input logic [4:0] k,
                     input logic ex, input logic [15:0] mant);
    send(sel, w);
    check({tag, ".valid"},   32'(bus.out_valid),   32'd1);
    check({tag, ".id"},      32'(bus.out_id),      32'(sel));
    check({tag, ".is_zero"}, 32'(bus.out_is_zero), 32'(zero));
    check({tag, ".is_inf"},  32'(bus.out_is_inf),  32'(inf));
    check({tag, ".sign"},    32'(bus.out_sign),    32'(sgn));
    check({tag, ".reg_len"}, 32'(bus.out_reg_len), 32'(len));
    check({tag, ".k"},       32'(bus.out_k),       32'(k));
    check({tag, ".exp"},     32'(bus.out_exp),     32'(ex));
    check({tag, ".mant"},    32'(bus.out_mant),    32'(mant));
  endtask

  initial begin
    rst            = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_bits  = 16'h4000;
    bus.req1_bits  = 16'h5000;
    bus.out_ready  = 1'b1;

    // Reset held with both requesters valid: nothing captured
    repeat (3) step();
    check("rst.valid",  32'(bus.out_valid), 32'd0);
    check("rst.id",     32'(bus.out_id),    32'd0);
    check("rst.k",      32'(bus.out_k),     32'd0);
    check("rst.mant",   32'(bus.out_mant),  32'd0);
    check("rst.ready0", 32'(bus.req0_ready), 32'd1);
    check("rst.ready1", 32'(bus.req1_ready), 32'd0);
    rst = 1'b0;

    // Fairness: strict alternation starting from requester 0
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("fair%0d.valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("fair%0d.id", i),    32'(bus.out_id),    32'(i % 2));
      check($sformatf("fair%0d.exp", i),   32'(bus.out_exp),   32'(i % 2));
    end

    // Backpressure: last result (req1, 0x5000) held, no acceptance
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("bp%0d.ready0", i), 32'(bus.req0_ready), 32'd0);
      check($sformatf("bp%0d.ready1", i), 32'(bus.req1_ready), 32'd0);
      step();
      check($sformatf("bp%0d.valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp%0d.id", i),    32'(bus.out_id),    32'd1);
      check($sformatf("bp%0d.exp", i),   32'(bus.out_exp),   32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp.rel.ready0", 32'(bus.req0_ready), 32'd1);
    check("bp.rel.ready1", 32'(bus.req1_ready), 32'd0);
    step();
    check("bp.rel.valid", 32'(bus.out_valid), 32'd1);
    check("bp.rel.id",    32'(bus.out_id),    32'd0);
    check("bp.rel.exp",   32'(bus.out_exp),   32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
    check("drain.valid", 32'(bus.out_valid), 32'd0);

    //        tag      sel  word      zero inf  sgn  len    k      exp  mant
    dec("p4000", 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0, 5'd2,  5'd0,  1'b0, 16'h0000);
    dec("p5000", 1'b0, 16'h5000, 1'b0, 1'b0, 1'b0, 5'd2,  5'd0,  1'b1, 16'h0000);
    dec("p3000", 1'b0, 16'h3000, 1'b0, 1'b0, 1'b0, 5'd2,  5'h1F, 1'b1, 16'h0000);
    dec("p4800", 1'b1, 16'h4800, 1'b0, 1'b0, 1'b0, 5'd2,  5'd0,  1'b0, 16'h0800);
    dec("pC000", 1'b0, 16'hC000, 1'b0, 1'b0, 1'b1, 5'd2,  5'd0,  1'b0, 16'h0000);
    dec("p7FFF", 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 5'd16, 5'd14, 1'b0, 16'h0000);
    dec("p0000", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 16'h0000);
    send(1'b1, 16'h8000);
    check("p8000.is_inf",  32'(bus.out_is_inf),  32'd1);
    check("p8000.is_zero", 32'(bus.out_is_zero), 32'd0);
    check("p8000.id",      32'(bus.out_id),      32'd1);

    // Load a result, stall it, then reset asynchronously between edges
    send(1'b0, 16'h4800);
    bus.out_ready = 1'b0;
    check("mid.pre.valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid.valid", 32'(bus.out_valid), 32'd0);
    check("mid.mant",  32'(bus.out_mant),  32'd0);
    check("mid.id",    32'(bus.out_id),    32'd0);
    step();
    rst            = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_bits  = 16'h4000;
    bus.req1_bits  = 16'h5000;
    bus.out_ready  = 1'b1;
    #1;
    check("mid.rel.ready0", 32'(bus.req0_ready), 32'd1);
    check("mid.rel.ready1", 32'(bus.req1_ready), 32'd0);
    step();
    check("mid.rel.valid", 32'(bus.out_valid), 32'd1);
    check("mid.rel.id",    32'(bus.out_id),    32'd0);
    step();
    check("mid.rel2.id",   32'(bus.out_id),    32'd1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
